stream_framer: RTL
==================

# stream_framer

Parametrised byte-lane I/O framer between the chip's narrow serial pins and the AES/SHA3 crypto core. It deserialises salt, password and message fields from `i_data` into wide registers and hands them to the core with single-cycle strobes. It serialises the 128-bit cipher and 256-bit HMAC results back out on `o_data` with `o_valid`. It generalises the fixed 8-bit, fixed-length top-level I/O to configurable lane width and field lengths, with a flow-control output and an optional abort/error path.

## Interface
- `BPB`, 1: bytes per beat; `DATA_W = 8*BPB`; legal values 1, 2, 4.
- `SALT_BYTES`, 16: salt field length in bytes.
- `PW_BYTES`, 15: password field length in bytes; legal range 1..32.
- `MSG_BYTES`, 16: message field length in bytes.
- `CT_BYTES`, 16: cipher result length in bytes.
- `MAC_BYTES`, 32: HMAC result length in bytes.
- `clk`  in  1  clock; one clock domain.
- `rst_n`  in  1  synchronous, active-low reset.
- `i_data`  in  DATA_W  input beat.
- `i_start`  in  1  beat valid.
- `i_mode`  in  1  mode bit, sampled on the first salt beat.
- `o_ien`  out  1  framer accepts beats this cycle.
- `o_data`  out  DATA_W  output beat.
- `o_valid`  out  1  `o_data` valid.
- `o_err`  out  1  one-cycle abort pulse; driven only with `STREAM_FRAMER_ABORT_EN`, otherwise tied 0.
- `k_salt`  out  8*SALT_BYTES  salt field to the core.
- `k_pw`  out  8*PW_BYTES  password field to the core.
- `k_msg`  out  8*MSG_BYTES  message field to the core.
- `k_mode`  out  1  latched mode bit.
- `k_key_vld`  out  1  one-cycle strobe: salt and password are stable.
- `k_msg_vld`  out  1  one-cycle strobe: message is stable.
- `k_ct`  in  8*CT_BYTES  cipher result from the core.
- `k_ct_vld`  in  1  cipher result strobe.
- `k_mac`  in  8*MAC_BYTES  HMAC result from the core.
- `k_mac_vld`  in  1  HMAC result strobe.

## Operation
- A beat is accepted when `i_start && o_ien`.
- Field beats: `ceil(bytes/BPB)`.
- Input byte order: the first byte received is the field MSB. Within a beat, the highest lane carries the earlier byte.
- Partial last input beat: only the top `bytes mod BPB` lanes are used; the rest are discarded.
- Output byte order: the result LSB goes out first; lane 0 is the lower byte.
- Partial last output beat: unused upper lanes are driven to 0.
- Input FSM:
  - `S_KEY`: `o_ien`=1; receives salt beats, then password beats, as one continuous count.
  - `S_KSTB`: `o_ien`=0; `k_key_vld`=1 for 1 cycle.
  - `S_MSG`: `o_ien`=1; receives message beats.
  - `S_RUN`: `o_ien`=0; `k_msg_vld` pulses on the first cycle. The FSM holds here until the last MAC beat has been sent, then goes to `S_KEY`.
- Output FSM:
  - `O_IDLE`: waits until a cipher result is latched.
  - `O_CT`: sends the cipher beats.
  - `O_GAP`: 1 cycle, `o_valid`=0.
  - `O_MAC`: waits for the latched MAC, then sends its beats.
  - Back to `O_IDLE`.
- `k_ct_vld` and `k_mac_vld` each load a holding register plus a pending flag, in any order or in the same cycle. Output order is always cipher, then MAC.
- A strobe that arrives while its pending flag is already set is ignored.
- `i_start` outside `S_KEY`/`S_MSG` is ignored.
- Field registers hold their value until overwritten by the next pattern.

## Timing
- Reset values:
  - `o_ien`=1 (state `S_KEY`).
  - `o_valid`, `o_err`, `k_key_vld`, `k_msg_vld`, `k_mode` = 0.
  - `o_data` = 0; `k_*` field registers = 0.
  - Pending flags and all counters = 0.
- Reset mid-operation: everything returns to the reset values in the next cycle; partial fields and pending results are dropped.
- `k_key_vld` is high in the cycle after the last key beat is accepted.
- `o_ien` is low for exactly 1 cycle (`S_KSTB`), then high again for the message field.
- `k_msg_vld` is high in the cycle after the last message beat; `o_ien` stays low from that cycle on.
- First cipher beat: the cycle after `k_ct_vld` is sampled.
- Beats are back-to-back; `o_valid` never drops mid-field.
- MAC beats start no earlier than 2 cycles after the last cipher beat (the `O_GAP` cycle), guaranteeing a fresh `o_valid` rising edge.
- `o_ien` rises the cycle after the last MAC beat.

## Configuration
- `STREAM_FRAMER_ABORT_EN` defined:
  - `i_start` low after at least one beat of the current field (salt+password counted as one field, or the message) aborts the field.
  - `o_err` pulses for 1 cycle, the beat counter clears, and the FSM stays in the same state.
- Not defined:
  - Gaps hold the counter; the field resumes on the next accepted beat.
  - `o_err` is constant 0.

## Structure
- `stream_framer_pkg`:
  - input and output state enums;
  - `ceil_div` function;
  - default field-length localparams (16/15/16/16/32).
- Sub-module `framer_serializer`: loadable shift register plus beat counter, parametrised by byte count and `BPB`. Instantiated twice, for cipher and MAC.

## Test plan
- BPB=1, salt 0x00..0x0F then password 0x10..0x1E, `i_mode`=1:
  - `k_key_vld` pulses 1 cycle after beat 31 with `k_salt`=0x000102…0F, `k_pw`=0x1011…1E, `k_mode`=1;
  - `o_ien` is low for exactly 1 cycle.
- Message 0xA0..0xAF then `k_ct_vld` with `k_ct`=0x…0201:
  - `o_data` sequence is 01, 02, … for 16 beats, `o_valid` contiguous.
- `k_mac_vld` and `k_ct_vld` in the same cycle:
  - 16 cipher beats, 1 idle cycle, then 32 MAC beats;
  - `o_ien`=1 the cycle after the last MAC beat.
- BPB=2, PW_BYTES=15:
  - password takes 8 beats; the low lane of the last beat is ignored;
  - cipher takes 8 beats; the MAC's 16th beat is complete.
- Abort build: drop `i_start` after 5 salt beats:
  - `o_err` pulses 1 cycle;
  - the next 31 beats complete the key normally.
- `rst_n`=0 during `O_MAC`:
  - next cycle `o_valid`=0 and `o_ien`=1;
  - a new pattern runs correctly.

Source files
------------

// File: rtl/stream_framer_pkg.sv
// stream_framer_pkg -- shared types and helpers for the stream framer.
//   in_state_t  : input-side FSM states (key field, key strobe, message, run)
//   out_state_t : output-side FSM states (idle, cipher, gap, MAC)
//   ceil_div    : beats needed to carry a byte count over a lane width
//   DEF_*_BYTES : default field lengths
package stream_framer_pkg;

  typedef enum logic [1:0] {S_KEY, S_KSTB, S_MSG, S_RUN} in_state_t;
  typedef enum logic [1:0] {O_IDLE, O_CT, O_GAP, O_MAC} out_state_t;

  localparam int DEF_SALT_BYTES = 16;
  localparam int DEF_PW_BYTES   = 15;
  localparam int DEF_MSG_BYTES  = 16;
  localparam int DEF_CT_BYTES   = 16;
  localparam int DEF_MAC_BYTES  = 32;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/framer_serializer.sv
// framer_serializer -- loadable shift register that emits a BYTES-wide
// result as ceil(BYTES/BPB) beats, LSB first, lane 0 = lower byte.
// Unused upper lanes of a partial last beat come out as 0 (zero padding).
//   clk, rst_n : clock, synchronous active-low reset (beat counter only)
//   load       : capture din and restart the beat count
//   pop        : current beat consumed, advance to the next one
//   din        : result word
//   beat_nxt   : beat that will be at the head after this clock edge
//   last       : the beat currently at the head is the final one
module framer_serializer
  import stream_framer_pkg::*;
#(
  parameter int BYTES = 16,
  parameter int BPB   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 pop,
  input  logic [8*BYTES-1:0]   din,
  output logic [8*BPB-1:0]     beat_nxt,
  output logic                 last
);

  localparam int DATA_W = 8 * BPB;
  localparam int BEATS  = ceil_div(BYTES, BPB);
  localparam int SR_W   = DATA_W * BEATS;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [SR_W-1:0]  sr_q;
  logic [SR_W-1:0]  sr_d;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    sr_d = sr_q;
    if (load)
      sr_d = SR_W'(din);
    else if (pop)
      sr_d = sr_q >> DATA_W;
  end

  always_ff @(posedge clk) begin
    sr_q <= sr_d;
    if (!rst_n)
      cnt_q <= '0;
    else if (load)
      cnt_q <= '0;
    else if (pop)
      cnt_q <= last ? '0 : cnt_q + 1'b1;
  end

  assign beat_nxt = sr_d[DATA_W-1:0];
  assign last     = (cnt_q == CNT_W'(BEATS - 1));

endmodule

// File: rtl/stream_framer.sv
// stream_framer -- byte-lane framer between the serial pins and the crypto
// core. Deserialises salt+password (one continuous key field) and message
// into wide registers, strobes them to the core, and serialises the cipher
// then the HMAC result back out.
// Optional feature: define STREAM_FRAMER_ABORT_EN to make an i_start gap
// inside a field abort it (o_err pulse, counter cleared); otherwise gaps just
// pause the field and o_err is tied 0.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   i_data/i_start/i_mode input beat, beat valid, mode (first salt beat)
//   o_ien                framer accepts beats this cycle
//   o_data/o_valid       output beat and its valid
//   o_err                abort pulse
//   k_salt/k_pw/k_msg    fields to the core, k_mode latched mode bit
//   k_key_vld/k_msg_vld  single-cycle field strobes
//   k_ct/k_ct_vld        cipher result from the core
//   k_mac/k_mac_vld      HMAC result from the core
module stream_framer
  import stream_framer_pkg::*;
#(
  parameter int BPB        = 1,
  parameter int SALT_BYTES = DEF_SALT_BYTES,
  parameter int PW_BYTES   = DEF_PW_BYTES,
  parameter int MSG_BYTES  = DEF_MSG_BYTES,
  parameter int CT_BYTES   = DEF_CT_BYTES,
  parameter int MAC_BYTES  = DEF_MAC_BYTES,
  localparam int DATA_W    = 8 * BPB
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_W-1:0]       i_data,
  input  logic                    i_start,
  input  logic                    i_mode,
  output logic                    o_ien,
  output logic [DATA_W-1:0]       o_data,
  output logic                    o_valid,
  output logic                    o_err,
  output logic [8*SALT_BYTES-1:0] k_salt,
  output logic [8*PW_BYTES-1:0]   k_pw,
  output logic [8*MSG_BYTES-1:0]  k_msg,
  output logic                    k_mode,
  output logic                    k_key_vld,
  output logic                    k_msg_vld,
  input  logic [8*CT_BYTES-1:0]   k_ct,
  input  logic                    k_ct_vld,
  input  logic [8*MAC_BYTES-1:0]  k_mac,
  input  logic                    k_mac_vld
);

  localparam int SALT_BEATS = ceil_div(SALT_BYTES, BPB);
  localparam int PW_BEATS   = ceil_div(PW_BYTES, BPB);
  localparam int MSG_BEATS  = ceil_div(MSG_BYTES, BPB);
  localparam int KEY_BEATS  = SALT_BEATS + PW_BEATS;
  localparam int MAX_BEATS  = (KEY_BEATS > MSG_BEATS) ? KEY_BEATS : MSG_BEATS;
  localparam int CNT_W      = $clog2(MAX_BEATS + 1);
  localparam int SALT_W     = 8 * SALT_BYTES;
  localparam int PW_W       = 8 * PW_BYTES;
  localparam int MSG_W      = 8 * MSG_BYTES;
  // Bytes used in a partial last beat (0 = last beat is full)
  localparam int SALT_R     = SALT_BYTES % BPB;
  localparam int PW_R       = PW_BYTES % BPB;
  localparam int MSG_R      = MSG_BYTES % BPB;

  in_state_t        ist;
  out_state_t       ost;
  logic [CNT_W-1:0] beat_cnt;
  logic accept, in_salt, salt_beat, pw_beat, msg_beat;
  logic salt_last, key_last, msg_last, gap_abort;
  logic ct_pend, mac_pend, ct_ld, mac_ld, ct_pop, mac_pop, ct_last, mac_last, mac_done;
  logic [DATA_W-1:0] ct_beat_nxt, mac_beat_nxt;

  assign accept    = i_start && o_ien;
  assign in_salt   = (beat_cnt < CNT_W'(SALT_BEATS));
  assign salt_beat = accept && (ist == S_KEY) && in_salt;
  assign pw_beat   = accept && (ist == S_KEY) && !in_salt;
  assign msg_beat  = accept && (ist == S_MSG);
  assign salt_last = (beat_cnt == CNT_W'(SALT_BEATS - 1));
  assign key_last  = (beat_cnt == CNT_W'(KEY_BEATS - 1));
  assign msg_last  = (beat_cnt == CNT_W'(MSG_BEATS - 1));

`ifdef STREAM_FRAMER_ABORT_EN
  // o_ien is high only in S_KEY/S_MSG, so this fires only inside a field
  assign gap_abort = !i_start && o_ien && (beat_cnt != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) o_err <= 1'b0;
    else        o_err <= gap_abort;
  end
`else
  assign gap_abort = 1'b0;
  assign o_err     = 1'b0;
`endif

  // Input FSM: key field, key strobe, message field, wait for results
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ist       <= S_KEY;
      beat_cnt  <= '0;
      o_ien     <= 1'b1;
      k_key_vld <= 1'b0;
      k_msg_vld <= 1'b0;
      k_mode    <= 1'b0;
    end else begin
      k_key_vld <= 1'b0;
      k_msg_vld <= 1'b0;
      case (ist)
        S_KEY: begin
          if (accept) begin
            if (beat_cnt == '0) k_mode <= i_mode;
            if (key_last) begin
              beat_cnt  <= '0;
              ist       <= S_KSTB;
              o_ien     <= 1'b0;
              k_key_vld <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end else if (gap_abort) begin
            beat_cnt <= '0;
          end
        end
        S_KSTB: begin
          ist   <= S_MSG;
          o_ien <= 1'b1;
        end
        S_MSG: begin
          if (accept) begin
            if (msg_last) begin
              beat_cnt  <= '0;
              ist       <= S_RUN;
              o_ien     <= 1'b0;
              k_msg_vld <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end else if (gap_abort) begin
            beat_cnt <= '0;
          end
        end
        S_RUN: begin
          if (mac_done) begin
            ist   <= S_KEY;
            o_ien <= 1'b1;
          end
        end
      endcase
    end
  end

  // Field shift-in: first byte ends up as the MSB. A partial last beat
  // shifts in only its top lanes, which carry the earlier bytes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k_salt <= '0;
      k_pw   <= '0;
      k_msg  <= '0;
    end else begin
      if (salt_beat)
        k_salt <= (SALT_R != 0 && salt_last)
                  ? ((k_salt << (8 * SALT_R)) | SALT_W'(i_data >> (8 * (BPB - SALT_R))))
                  : ((k_salt << DATA_W) | SALT_W'(i_data));
      if (pw_beat)
        k_pw <= (PW_R != 0 && key_last)
                ? ((k_pw << (8 * PW_R)) | PW_W'(i_data >> (8 * (BPB - PW_R))))
                : ((k_pw << DATA_W) | PW_W'(i_data));
      if (msg_beat)
        k_msg <= (MSG_R != 0 && msg_last)
                 ? ((k_msg << (8 * MSG_R)) | MSG_W'(i_data >> (8 * (BPB - MSG_R))))
                 : ((k_msg << DATA_W) | MSG_W'(i_data));
    end
  end

  // The serializers double as the holding registers; a strobe is only
  // taken when its pending flag is clear.
  assign ct_ld    = k_ct_vld && !ct_pend;
  assign mac_ld   = k_mac_vld && !mac_pend;
  assign ct_pop   = (ost == O_CT);
  assign mac_pop  = (ost == O_MAC) && o_valid;
  assign mac_done = mac_pop && mac_last;

  framer_serializer #(.BYTES(CT_BYTES), .BPB(BPB)) u_ct_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ct_ld),
    .pop      (ct_pop),
    .din      (k_ct),
    .beat_nxt (ct_beat_nxt),
    .last     (ct_last)
  );

  framer_serializer #(.BYTES(MAC_BYTES), .BPB(BPB)) u_mac_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (mac_ld),
    .pop      (mac_pop),
    .din      (k_mac),
    .beat_nxt (mac_beat_nxt),
    .last     (mac_last)
  );

  // Output FSM: o_data is registered from the serializer's next head, so
  // the first beat appears the cycle after the result strobe is sampled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ost      <= O_IDLE;
      o_valid  <= 1'b0;
      o_data   <= '0;
      ct_pend  <= 1'b0;
      mac_pend <= 1'b0;
    end else begin
      if (ct_ld)  ct_pend  <= 1'b1;
      if (mac_ld) mac_pend <= 1'b1;
      case (ost)
        O_IDLE: begin
          if (ct_pend || ct_ld) begin
            ost     <= O_CT;
            o_valid <= 1'b1;
            o_data  <= ct_beat_nxt;
          end
        end
        O_CT: begin
          if (ct_last) begin
            ost     <= O_GAP;
            o_valid <= 1'b0;
            o_data  <= '0;
            ct_pend <= 1'b0;
          end else begin
            o_data <= ct_beat_nxt;
          end
        end
        O_GAP: begin
          ost <= O_MAC;
          if (mac_pend || mac_ld) begin
            o_valid <= 1'b1;
            o_data  <= mac_beat_nxt;
          end
        end
        O_MAC: begin
          if (!o_valid) begin
            if (mac_pend || mac_ld) begin
              o_valid <= 1'b1;
              o_data  <= mac_beat_nxt;
            end
          end else if (mac_last) begin
            ost      <= O_IDLE;
            o_valid  <= 1'b0;
            o_data   <= '0;
            mac_pend <= 1'b0;
          end else begin
            o_data <= mac_beat_nxt;
          end
        end
      endcase
    end
  end

endmodule
